data_mem_responder: RTL

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

---
 rtl/mem_resp_pkg.sv | 22 ++
 rtl/data_mem_array.sv | 26 ++
 rtl/data_mem_responder.sv | 118 +++++++++++
 3 files changed

// File: rtl/mem_resp_pkg.sv
// Shared types and constants for the data memory responder.
package mem_resp_pkg;

  localparam int WORD_W  = 32;
  localparam int LAT_MIN = 1;
  localparam int LAT_MAX = 15;
  localparam int CNT_W   = 4;   // wide enough for LAT_MAX-1

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  // Request as captured at acceptance.
  typedef struct packed {
    logic              write;
    logic [WORD_W-1:0] addr;
    logic [WORD_W-1:0] wdata;
  } req_t;

endpackage

// File: rtl/data_mem_array.sv
// Word storage: one synchronous write port, one combinational read port.
// Contents are zero at simulation start and are never touched by reset.
module data_mem_array
  import mem_resp_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [WORD_W-1:0] wdata_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [WORD_W-1:0] rdata_o
);

  logic [WORD_W-1:0] mem_q [DEPTH] = '{default: '0};

  // Write port: commits on the rising edge when enabled.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/data_mem_responder.sv
// Single-outstanding memory responder: accept a request in IDLE, wait a
// fixed latency, commit load/store to storage, then hold the response
// until the initiator takes it.
module data_mem_responder
  import mem_resp_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [WORD_W-1:0] req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [WORD_W-1:0] resp_rdata,
  output logic              resp_err
);

  localparam int AW = $clog2(DEPTH_WORDS);
  // Latency outside the supported range is clamped rather than wrapping the counter.
  localparam int LAT_C = (LATENCY < LAT_MIN) ? LAT_MIN :
                         (LATENCY > LAT_MAX) ? LAT_MAX : LATENCY;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LAT_C - 1);

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  req_t              req_q;
  logic              req_ready_q;
  logic              resp_valid_q;
  logic              resp_err_q;
  logic [WORD_W-1:0] resp_rdata_q;

  logic [AW-1:0]     idx;
  logic              addr_err;
  logic              commit;
  logic              mem_we;
  logic [WORD_W-1:0] mem_rdata;

  // Bits above the word index only take part in the range check.
  assign idx      = req_q.addr[AW+1:2];
  assign addr_err = (req_q.addr[1:0] != 2'b00) ||
                    ({2'b00, req_q.addr[WORD_W-1:2]} >= 32'(DEPTH_WORDS));
  assign commit   = (state_q == WAIT) && (cnt_q == '0);
  assign mem_we   = commit && req_q.write && !addr_err;

  data_mem_array #(
    .DEPTH (DEPTH_WORDS),
    .AW    (AW)
  ) u_mem (
    .clk     (clk),
    .we_i    (mem_we),
    .waddr_i (idx),
    .wdata_i (req_q.wdata),
    .raddr_i (idx),
    .rdata_o (mem_rdata)
  );

  // Control FSM with latency counter, request capture and registered response.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      req_q        <= '0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            req_q.write <= req_write;
            req_q.addr  <= req_addr;
            req_q.wdata <= req_wdata;
            cnt_q       <= CNT_INIT;
            req_ready_q <= 1'b0;
            state_q     <= WAIT;
          end
        end
        WAIT: begin
          if (cnt_q == '0) begin
            // Commit cycle: the store lands via mem_we, a load samples here.
            resp_err_q   <= addr_err;
            resp_rdata_q <= (!req_q.write && !addr_err) ? mem_rdata : '0;
            resp_valid_q <= 1'b1;
            state_q      <= RESP;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
            req_ready_q  <= 1'b1;
            state_q      <= IDLE;
          end
        end
        default: begin
          state_q      <= IDLE;
          req_ready_q  <= 1'b1;
          resp_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rdata_q;

endmodule
